// File: rtl/atm_pkg.sv
// Shared ATM UNI cell definitions: header layout, cell geometry, HEC helper
// and receive-FSM state encoding.
package atm_pkg;

   localparam int CELL_BYTES = 53;
   localparam int HDR_BYTES  = 5;
   localparam logic [7:0] HEC_COSET = 8'h55;

   typedef struct packed {
      logic [3:0]  gfc;
      logic [7:0]  vpi;
      logic [15:0] vci;
      logic [2:0]  pt;
      logic        clp;
      logic [7:0]  hec;
   } uni_hdr_t;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_COLLECT,
      ST_HOLD
   } rx_state_t;

   // CRC-8, x^8+x^2+x+1, init 0, MSB of the first header byte first.
   function automatic logic [7:0] hec_crc8(input logic [31:0] data);
      logic [7:0] crc;
      crc = 8'h00;
      for (int i = 31; i >= 0; i--) begin
         if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h07;
         else                  crc = {crc[6:0], 1'b0};
      end
      return crc;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_count <= '0;
      else if (inc && (r_count != '1))  r_count <= r_count + 1'b1;
   end

   assign count = r_count;

endmodule

// File: rtl/utopia_rx_cell_assembler.sv
// Utopia L1 Rx front end: delineates 53-byte cells on SOC, checks HEC and
// hands each cell to the core as one word over a valid/ready handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HUNT    | waiting for an accepted byte with rx_soc, others discarded
// ST_COLLECT | storing bytes into the assembly buffer at r_idx
// ST_HOLD    | full cell buffered, output word still occupied; rx_en_n=1
module utopia_rx_cell_assembler
   import atm_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int HEC_CHECK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_soc,
   input  logic             rx_clav,
   output logic             rx_en_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [39:0]      out_hdr,
   output logic [383:0]     out_payload,
   output logic [CNT_W-1:0] cell_cnt,
   output logic [CNT_W-1:0] hec_err_cnt,
   output logic [CNT_W-1:0] runt_cnt
);

   localparam logic [5:0] LAST_IDX = 6'(CELL_BYTES - 1);

   rx_state_t    r_state;
   logic [5:0]   r_idx;
   logic         r_rx_en_n;
   logic         r_out_valid;
   logic [39:0]  r_out_hdr;
   logic [383:0] r_out_payload;
   logic [7:0]   r_hec_exp;
   logic         r_hec_ok;
   logic [7:0]   r_buf [CELL_BYTES];

   logic         w_accept;
   logic         w_out_free;
   logic         w_last_byte;
   logic         w_hec_inc;
   logic         w_drop;
   logic         w_runt_inc;
   logic         w_load;
   uni_hdr_t     w_hdr;
   logic [383:0] w_payload;

   assign w_accept    = !r_rx_en_n && rx_clav;
   assign w_out_free  = !r_out_valid || out_ready;
   assign w_runt_inc  = (r_state == ST_COLLECT) && w_accept && rx_soc;
   assign w_last_byte = (r_state == ST_COLLECT) && w_accept && !rx_soc && (r_idx == LAST_IDX);
   assign w_hec_inc   = w_last_byte && !r_hec_ok;
   assign w_drop      = w_hec_inc && (HEC_CHECK != 0);
   assign w_load      = (w_last_byte && !w_drop && w_out_free) ||
                        ((r_state == ST_HOLD) && r_out_valid && out_ready);

   // Byte 52 comes straight from rx_data when the cell is loaded on arrival.
   assign w_hdr = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4]};

   always_comb begin
      w_payload = '0;
      for (int i = 0; i < CELL_BYTES - HDR_BYTES; i++)
         w_payload[383 - 8*i -: 8] = r_buf[HDR_BYTES + i];
      if (r_state != ST_HOLD) w_payload[7:0] = rx_data;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         if (rx_soc)                        r_buf[0]     <= rx_data;
         else if (r_state == ST_COLLECT)    r_buf[r_idx] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_HUNT;
         r_idx         <= '0;
         r_rx_en_n     <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_hdr     <= '0;
         r_out_payload <= '0;
         r_hec_exp     <= '0;
         r_hec_ok      <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_hdr     <= w_hdr;
            r_out_payload <= w_payload;
            r_out_valid   <= 1'b1;
         end else if (out_ready) begin
            r_out_valid   <= 1'b0;
         end

         r_rx_en_n <= 1'b0;
         case (r_state)
            ST_HUNT: begin
               if (w_accept && rx_soc) begin
                  r_state <= ST_COLLECT;
                  r_idx   <= 6'd1;
               end
            end
            ST_COLLECT: begin
               if (w_accept) begin
                  if (rx_soc) begin
                     r_idx <= 6'd1;
                  end else begin
                     r_idx <= r_idx + 6'd1;
                     if (r_idx == 6'd3)
                        r_hec_exp <= hec_crc8({r_buf[0], r_buf[1], r_buf[2], rx_data}) ^ HEC_COSET;
                     if (r_idx == 6'd4)
                        r_hec_ok <= (rx_data == r_hec_exp);
                     if (r_idx == LAST_IDX) begin
                        r_idx <= '0;
                        if (w_drop || w_out_free) begin
                           r_state <= ST_HUNT;
                        end else begin
                           r_state   <= ST_HOLD;
                           r_rx_en_n <= 1'b1;
                        end
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (r_out_valid && out_ready) r_state   <= ST_HUNT;
               else                          r_rx_en_n <= 1'b1;
            end
            default: r_state <= ST_HUNT;
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cell_cnt (
      .clk(clk), .rst_n(rst_n), .inc(w_load), .count(cell_cnt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_hec_err_cnt (
      .clk(clk), .rst_n(rst_n), .inc(w_hec_inc), .count(hec_err_cnt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_runt_cnt (
      .clk(clk), .rst_n(rst_n), .inc(w_runt_inc), .count(runt_cnt)
   );

   assign rx_en_n     = r_rx_en_n;
   assign out_valid   = r_out_valid;
   assign out_hdr     = r_out_hdr;
   assign out_payload = r_out_payload;

endmodule

// File: tb/tb_utopia_rx_cell_assembler.sv
// Bench for utopia_rx_cell_assembler: directed scenarios plus randomized
// cell streams checked against a queue of expected cells and event counts.
module tb_utopia_rx_cell_assembler;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   rx_data = '0;
   logic         rx_soc = 1'b0;
   logic         rx_clav = 1'b0;
   logic         out_ready = 1'b0;
   logic         rx_en_n, out_valid;
   logic [39:0]  out_hdr;
   logic [383:0] out_payload;
   logic [15:0]  cell_cnt, hec_err_cnt, runt_cnt;
   logic         rx_en_n_0, out_valid_0;
   logic [39:0]  out_hdr_0;
   logic [383:0] out_payload_0;
   logic [15:0]  cell_cnt_0, hec_err_cnt_0, runt_cnt_0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int clav_mode = 0;
   bit tog = 1'b1;
   logic [423:0] exp_q[$];

   utopia_rx_cell_assembler #(.CNT_W(16), .HEC_CHECK(1)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_soc(rx_soc), .rx_clav(rx_clav),
      .rx_en_n(rx_en_n), .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
      .out_payload(out_payload), .cell_cnt(cell_cnt), .hec_err_cnt(hec_err_cnt), .runt_cnt(runt_cnt)
   );

   utopia_rx_cell_assembler #(.CNT_W(16), .HEC_CHECK(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_soc(rx_soc), .rx_clav(rx_clav),
      .rx_en_n(rx_en_n_0), .out_valid(out_valid_0), .out_ready(out_ready), .out_hdr(out_hdr_0),
      .out_payload(out_payload_0), .cell_cnt(cell_cnt_0), .hec_err_cnt(hec_err_cnt_0), .runt_cnt(runt_cnt_0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // HEC as the remainder of (header * x^8) divided by the generator, then the coset.
   function automatic logic [7:0] ref_hec(input logic [31:0] h);
      logic [39:0] r;
      r = {h, 8'h00};
      for (int i = 39; i >= 8; i--) if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      return r[7:0] ^ 8'h55;
   endfunction

   function automatic logic [423:0] mk_cell(input logic [3:0] gfc, input logic [7:0] vpi,
                                            input logic [15:0] vci, input logic [2:0] pt,
                                            input logic clp, input logic [383:0] pay);
      logic [31:0] h;
      h = {gfc, vpi, vci, pt, clp};
      return {h, ref_hec(h), pay};
   endfunction

   function automatic logic [423:0] rand_cell();
      logic [383:0] pay;
      for (int i = 0; i < 12; i++) pay[32*i +: 32] = $urandom;
      return mk_cell(4'($urandom), 8'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), pay);
   endfunction

   // Output handshake observer, sampling 1 ns before each rising edge.
   always @(negedge clk) begin
      #4;
      if (rst_n && out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_cell got hdr=%h with nothing expected", out_hdr);
         end else begin
            logic [423:0] e;
            e = exp_q.pop_front();
            if ({out_hdr, out_payload} !== e) begin
               n_fail++;
               $display("FAIL cell_data got %h want %h", {out_hdr, out_payload}, e);
            end
         end
      end
   end

   task automatic drive_byte(input logic [7:0] d, input logic soc);
      int guard;
      guard = 0;
      forever begin
         @(negedge clk);
         rx_data = d;
         rx_soc  = soc;
         case (clav_mode)
            1:       begin tog = ~tog; rx_clav = tog; end
            2:       rx_clav = ($urandom_range(99) < 70);
            default: rx_clav = 1'b1;
         endcase
         if (rx_clav && !rx_en_n) break;
         guard++;
         if (guard > 1000) begin
            n_tests++; n_fail++;
            $display("FAIL drive_timeout got rx_en_n=%b want byte accepted within 1000 cycles", rx_en_n);
            break;
         end
      end
   endtask

   task automatic send_bytes(input logic [423:0] c, input int n);
      for (int k = 0; k < n; k++) drive_byte(c[423 - 8*k -: 8], k == 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); rx_clav = 1'b0; rx_soc = 1'b0; end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; rx_clav = 1'b0; rx_soc = 1'b0; rx_data = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++; if (rx_en_n !== 1'b0) begin n_fail++; $display("FAIL reset_rx_en_n got %b want 0", rx_en_n); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++; if ({out_hdr, out_payload} !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_hdr); end
      n_tests++; if ({cell_cnt, hec_err_cnt, runt_cnt} !== '0) begin n_fail++;
         $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cell_cnt, hec_err_cnt, runt_cnt); end
   endtask

   task automatic test_good_cell();
      logic [383:0] pay;
      logic [423:0] c;
      apply_reset();
      out_ready = 1'b1; clav_mode = 0;
      for (int i = 0; i < 48; i++) pay[383 - 8*i -: 8] = 8'(i);
      c = mk_cell(4'h0, 8'h12, 16'h3456, 3'h0, 1'b0, pay);
      exp_q.push_back(c);
      send_bytes(c, 53);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_early_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL good_latency got out_valid=%b want 1", out_valid); end
      n_tests++; if (out_hdr[35:28] !== 8'h12) begin n_fail++; $display("FAIL good_vpi got %h want 12", out_hdr[35:28]); end
      n_tests++; if (out_payload[383:376] !== 8'h00) begin n_fail++; $display("FAIL good_byte5 got %h want 00", out_payload[383:376]); end
      n_tests++; if (cell_cnt !== 16'd1) begin n_fail++; $display("FAIL good_cell_cnt got %0d want 1", cell_cnt); end
      idle(3);
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL good_delivered got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_bad_hec();
      logic [423:0] c;
      apply_reset();
      out_ready = 1'b1; clav_mode = 0;
      c = rand_cell();
      c[391:384] = c[391:384] ^ 8'h01;
      send_bytes(c, 53);
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bad_hec_dropped got out_valid=%b want 0", out_valid); end
      n_tests++; if (hec_err_cnt !== 16'd1) begin n_fail++; $display("FAIL bad_hec_cnt got %0d want 1", hec_err_cnt); end
      n_tests++; if (cell_cnt !== 16'd0) begin n_fail++; $display("FAIL bad_hec_cell_cnt got %0d want 0", cell_cnt); end
      n_tests++; if (out_valid_0 !== 1'b1) begin n_fail++; $display("FAIL nochk_forward got out_valid=%b want 1", out_valid_0); end
      n_tests++; if ({out_hdr_0, out_payload_0} !== c) begin n_fail++; $display("FAIL nochk_data got %h want %h", out_hdr_0, c[423:384]); end
      n_tests++; if ({cell_cnt_0, hec_err_cnt_0} !== {16'd1, 16'd1}) begin n_fail++;
         $display("FAIL nochk_counts got %0d/%0d want 1/1", cell_cnt_0, hec_err_cnt_0); end
      idle(3);
   endtask

   task automatic test_runt();
      logic [423:0] a, b;
      apply_reset();
      out_ready = 1'b1; clav_mode = 0;
      a = rand_cell(); b = rand_cell();
      exp_q.push_back(b);
      send_bytes(a, 20);
      send_bytes(b, 53);
      idle(4);
      n_tests++; if (runt_cnt !== 16'd1) begin n_fail++; $display("FAIL runt_cnt got %0d want 1", runt_cnt); end
      n_tests++; if (cell_cnt !== 16'd1) begin n_fail++; $display("FAIL runt_cell_cnt got %0d want 1", cell_cnt); end
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL runt_delivered got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [423:0] c1, c2;
      apply_reset();
      out_ready = 1'b0; clav_mode = 0;
      c1 = rand_cell(); c2 = rand_cell();
      exp_q.push_back(c1); exp_q.push_back(c2);
      send_bytes(c1, 53);
      send_bytes(c2, 53);
      @(posedge clk); #1;
      n_tests++; if (rx_en_n !== 1'b1) begin n_fail++; $display("FAIL hold_rx_en_n got %b want 1", rx_en_n); end
      idle(4);
      n_tests++; if ({out_valid, out_hdr, out_payload} !== {1'b1, c1}) begin n_fail++;
         $display("FAIL hold_stable got v=%b hdr=%h want v=1 hdr=%h", out_valid, out_hdr, c1[423:384]); end
      n_tests++; if (rx_en_n !== 1'b1) begin n_fail++; $display("FAIL hold_rx_en_n_stays got %b want 1", rx_en_n); end
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      #1;
      n_tests++; if ({out_valid, out_hdr, out_payload} !== {1'b1, c2}) begin n_fail++;
         $display("FAIL hold_second got v=%b hdr=%h want v=1 hdr=%h", out_valid, out_hdr, c2[423:384]); end
      n_tests++; if (rx_en_n !== 1'b0) begin n_fail++; $display("FAIL hold_release got rx_en_n=%b want 0", rx_en_n); end
      n_tests++; if (cell_cnt !== 16'd2) begin n_fail++; $display("FAIL hold_cell_cnt got %0d want 2", cell_cnt); end
      out_ready = 1'b1;
      idle(3);
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_delivered got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_clav_toggle();
      logic [423:0] c;
      int c0;
      apply_reset();
      out_ready = 1'b1; clav_mode = 1; tog = 1'b1;
      c = rand_cell();
      exp_q.push_back(c);
      c0 = cyc + 1;
      send_bytes(c, 53);
      @(posedge clk); #1;
      n_tests++; if (cyc - c0 != 106) begin n_fail++; $display("FAIL clav_cycles got %0d want 106", cyc - c0); end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clav_valid got %b want 1", out_valid); end
      clav_mode = 0;
      idle(3);
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clav_delivered got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_cell();
      logic [423:0] a, b, c;
      apply_reset();
      out_ready = 1'b0; clav_mode = 0;
      a = rand_cell(); b = rand_cell(); c = rand_cell();
      send_bytes(a, 53);
      idle(1);
      n_tests++; if ({out_valid, out_hdr, out_payload} !== {1'b1, a}) begin n_fail++;
         $display("FAIL mid_held got v=%b hdr=%h want v=1 hdr=%h", out_valid, out_hdr, a[423:384]); end
      send_bytes(b, 30);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if ({rx_en_n, out_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ctrl got %b want 00", {rx_en_n, out_valid}); end
      n_tests++; if ({out_hdr, out_payload} !== '0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", out_hdr); end
      n_tests++; if (cell_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", cell_cnt); end
      exp_q.delete();
      idle(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(c);
      send_bytes(c, 53);
      idle(3);
      n_tests++; if (cell_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_next_cnt got %0d want 1", cell_cnt); end
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_delivered got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [423:0] c;
      int c0;
      apply_reset();
      out_ready = 1'b1; clav_mode = 0;
      idle(1);
      c0 = cyc + 1;
      for (int k = 0; k < 4; k++) begin
         c = rand_cell();
         exp_q.push_back(c);
         send_bytes(c, 53);
      end
      @(posedge clk); #1;
      n_tests++; if (cyc - c0 != 212) begin n_fail++; $display("FAIL b2b_cycles got %0d want 212", cyc - c0); end
      idle(3);
      n_tests++; if (cell_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_cell_cnt got %0d want 4", cell_cnt); end
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_delivered got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_random();
      int n_good, n_bad, n_runt, wait_cyc;
      bit done;
      n_good = 0; n_bad = 0; n_runt = 0; done = 1'b0;
      apply_reset();
      clav_mode = 2;
      fork
         begin
            for (int k = 0; k < 16; k++) begin
               logic [423:0] c;
               int kind;
               c = rand_cell();
               kind = $urandom_range(3);
               for (int j = 0; j < int'($urandom_range(2)); j++) drive_byte(8'($urandom), 1'b0);
               if (kind == 3) begin
                  send_bytes(rand_cell(), $urandom_range(1, 52));
                  n_runt++;
               end
               if (kind == 2) begin
                  c[391:384] = c[391:384] ^ (8'h01 << $urandom_range(7));
                  n_bad++;
               end else begin
                  exp_q.push_back(c);
                  n_good++;
               end
               send_bytes(c, 53);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin @(negedge clk); out_ready = 1'($urandom_range(1)); end
         end
      join
      out_ready = 1'b1;
      clav_mode = 0;
      wait_cyc = 0;
      while (exp_q.size() != 0 && wait_cyc < 20) begin idle(1); wait_cyc++; end
      idle(2);
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_delivered got %0d pending want 0", exp_q.size()); end
      n_tests++; if (cell_cnt !== 16'(n_good)) begin n_fail++; $display("FAIL rand_cell_cnt got %0d want %0d", cell_cnt, n_good); end
      n_tests++; if (hec_err_cnt !== 16'(n_bad)) begin n_fail++; $display("FAIL rand_hec_cnt got %0d want %0d", hec_err_cnt, n_bad); end
      n_tests++; if (runt_cnt !== 16'(n_runt)) begin n_fail++; $display("FAIL rand_runt_cnt got %0d want %0d", runt_cnt, n_runt); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish before 500000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_good_cell();
      test_bad_hec();
      test_runt();
      test_backpressure();
      test_clav_toggle();
      test_reset_mid_cell();
      test_back_to_back();
      for (int r = 0; r < 3; r++) test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/utopia_rx_cell_assembler.md
# utopia_rx_cell_assembler

Receive-side front end for one UNI port of the ATM switch. It sits between a Level 1 Utopia Rx interface and the squat switch core. It accepts the byte-serial cell stream, delineates 53-byte cells on start-of-cell, checks the HEC, and presents each good cell as one parallel word to the core with a valid/ready handshake. Bad and truncated cells are dropped and counted.

## Interface
Parameters:
- CNT_W, 16, width of each statistics counter
- HEC_CHECK, 1, when 1, cells with a bad HEC are dropped; when 0, every complete cell is forwarded and only counted

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  Utopia cell byte
- rx_soc  in  1  marks byte 0 of a cell
- rx_clav  in  1  PHY has a byte available
- rx_en_n  out  1  receiver enable, active low, registered
- out_valid  out  1  a cell is held on out_hdr/out_payload
- out_ready  in  1  core accepts the cell
- out_hdr  out  40  uni_hdr_t: gfc[4], vpi[8], vci[16], pt[3], clp[1], hec[8]
- out_payload  out  384  payload; byte 5 of the cell is at [383:376]
- cell_cnt  out  CNT_W  good cells forwarded, saturating
- hec_err_cnt  out  CNT_W  cells with a bad HEC, saturating
- runt_cnt  out  CNT_W  cells aborted by an early rx_soc, saturating

## Operation
- Byte acceptance: a byte is accepted at a rising edge when rx_en_n==0 and rx_clav==1. No other condition applies.
- States:
  - HUNT: discard accepted bytes that have rx_soc==0. An accepted byte with rx_soc==1 is stored as byte 0 and the state moves to COLLECT with idx=1.
  - COLLECT: store the byte at idx and increment idx.
    - When the accepted byte has rx_soc==1, it is a runt: increment runt_cnt, store this byte as byte 0, set idx=1, and stay in COLLECT.
    - On the edge that accepts byte 3, compute CRC-8 over bytes 0–3 (polynomial x^8+x^2+x+1, init 0x00), XOR the result with 0x55, and compare it with byte 4 when byte 4 is accepted. Register the hec_ok result at the byte 4 edge.
    - Byte 52 accepted:
      - If hec_ok==0 and HEC_CHECK==1: increment hec_err_cnt, drop the cell, go to HUNT.
      - Else, if out_valid==0 or out_ready==1: load the output register, set out_valid=1, increment cell_cnt, go to HUNT.
      - Else: go to HOLD.
  - HOLD: rx_en_n=1. At the edge with out_valid && out_ready, load the output register from the assembly buffer, increment cell_cnt, go to HUNT.
- hec_err_cnt increments even when HEC_CHECK==0. Those cells are still forwarded.
- rx_en_n is a flop whose next value is 1 iff the next state is HOLD.
- out_valid clears on out_ready unless a new cell loads at the same edge.
- Counters saturate at all-ones.
- Outputs are stable while out_valid==1 and out_ready==0.

## Timing
- Reset values: state HUNT, idx 0, rx_en_n=0, out_valid=0, out_hdr=0, out_payload=0, all counters 0.
- Reset mid-cell discards the partial cell.
- The counters use no synchronizer; the core samples them only quasi-statically.
- Latency: when byte 52 is accepted at edge N with the output register free, out_valid=1 after edge N.
- From HOLD, the cell loads at the handshake edge, and rx_en_n=0 from the following cycle.
- Back-to-back cells are sustained at 53 cycles per cell when out_ready is held at 1.
- Gaps in rx_clav stall idx with no data loss.
- rx_soc on a cycle that is not accepted is ignored.

## Structure
- Package atm_pkg holds:
  - uni_hdr_t (packed struct)
  - HEC_COSET = 8'h55
  - CELL_BYTES = 53, HDR_BYTES = 5
  - function hec_crc8(input logic [31:0]) returning logic [7:0]
- Sub-module sat_counter #(CNT_W) with ports clk, rst_n, inc, and count, instantiated three times.
- Assembly buffer: a 53x8 register array. The output register is separate, giving double buffering.

## Test plan
- Good cell, header GFC=0, VPI=0x12, VCI=0x3456, PT=0, CLP=0, HEC computed, payload 0x00..0x2F → out_valid one cycle after byte 52, out_hdr.vpi=0x12, out_payload[383:376]=0x00, cell_cnt=1.
- Same cell with HEC ^ 0x01 → no out_valid, hec_err_cnt=1. Repeat with HEC_CHECK=0 → forwarded, cell_cnt=1 and hec_err_cnt=1.
- rx_soc reasserted at byte 20, followed by a full good cell → runt_cnt=1, exactly one cell out, and its payload matches the second cell.
- out_ready=0 while two good cells arrive → first cell held, rx_en_n=1 the cycle after the second cell's byte 52. out_ready=1 for one cycle → cell 1 consumed, cell 2 appears next cycle, rx_en_n=0 afterwards.
- rx_clav toggled 1/0 every cycle during a cell → cell assembled correctly, delivered after 106 cycles.
- rst_n pulsed low at byte 30 of a cell → all outputs return to reset values immediately. The next good cell is delivered and cell_cnt=1.
